// File: rtl/mmio_pwm_timer.sv
// Memory-mapped peripheral with four glitch-free PWM channels and free-running
// microsecond / millisecond counters, sharing the unified load/store bus with RAM.
module mmio_pwm_timer #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FFF0,
  parameter int          CLK_HZ       = 12_000_000,
  parameter int          PWM_PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write_mem,
  input  logic [2:0]  funct3,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  output logic        read_hit,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam int US_DIV = CLK_HZ / 1_000_000;
  localparam int US_W   = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int PRE_W  = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;

  logic [31:0]      duty;
  logic [31:0]      shadow;
  logic             pwm_en;
  logic [31:0]      us_cnt;
  logic [31:0]      ms_cnt;
  logic [US_W-1:0]  us_pre;
  logic [9:0]       ms_pre;
  logic [PRE_W-1:0] pwm_pre;
  logic [7:0]       pwm_cnt;
  logic             us_tick;

  logic        wr_window;
  logic [1:0]  wr_off;
  logic [3:0]  wr_mask;
  logic [31:0] wr_data;
  logic        duty_wr;
  logic        ctrl_wr;
  logic        clr;

  // Byte-lane mask of a store; zero for misaligned or unsupported widths.
  always_comb begin
    wr_window = write_mem && (write_address[31:4] == BASE_ADDR[31:4]);
    wr_off    = write_address[1:0];
    wr_data   = write_data << {wr_off, 3'b000};
    wr_mask   = 4'b0000;
    case (funct3)
      3'b000: wr_mask = 4'b0001 << wr_off;
      3'b001: if (!wr_off[0]) wr_mask = 4'b0011 << wr_off;
      3'b010: if (wr_off == 2'b00) wr_mask = 4'b1111;
      default: wr_mask = 4'b0000;
    endcase
    if (!wr_window) wr_mask = 4'b0000;
    duty_wr = (write_address[3:2] == 2'b00);
    ctrl_wr = (write_address[3:2] == 2'b11);
    clr     = ctrl_wr && wr_mask[0] && wr_data[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty   <= 32'h0;
      pwm_en <= 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (duty_wr && wr_mask[i]) duty[8*i +: 8] <= wr_data[8*i +: 8];
      end
      if (ctrl_wr && wr_mask[0]) pwm_en <= wr_data[0];
    end
  end

  assign us_tick = (us_pre == US_W'(US_DIV - 1));

  // Clear wins over a coincident tick so software always sees a clean zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      us_pre <= '0;
      ms_pre <= 10'd0;
      us_cnt <= 32'h0;
      ms_cnt <= 32'h0;
    end else if (clr) begin
      us_pre <= '0;
      ms_pre <= 10'd0;
      us_cnt <= 32'h0;
      ms_cnt <= 32'h0;
    end else begin
      us_pre <= us_tick ? '0 : us_pre + 1'b1;
      if (us_tick) begin
        us_cnt <= us_cnt + 32'd1;
        if (ms_pre == 10'd999) begin
          ms_pre <= 10'd0;
          ms_cnt <= ms_cnt + 32'd1;
        end else begin
          ms_pre <= ms_pre + 10'd1;
        end
      end
    end
  end

  // Shadows follow DUTY while disabled so re-enabling starts on current values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_pre <= '0;
      pwm_cnt <= 8'd0;
      shadow  <= 32'h0;
    end else if (!pwm_en) begin
      pwm_pre <= '0;
      pwm_cnt <= 8'd0;
      shadow  <= duty;
    end else if (pwm_pre == PRE_W'(PWM_PRESCALE - 1)) begin
      pwm_pre <= '0;
      pwm_cnt <= pwm_cnt + 8'd1;
      if (pwm_cnt == 8'd255) shadow <= duty;
    end else begin
      pwm_pre <= pwm_pre + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led   <= 1'b0;
      red   <= 1'b0;
      green <= 1'b0;
      blue  <= 1'b0;
    end else begin
      led   <= pwm_en && (pwm_cnt < shadow[7:0]);
      red   <= pwm_en && (pwm_cnt < shadow[15:8]);
      green <= pwm_en && (pwm_cnt < shadow[23:16]);
      blue  <= pwm_en && (pwm_cnt < shadow[31:24]);
    end
  end

  logic        rd_window;
  logic [1:0]  rd_off;
  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [31:0] rd_value;

  // Load path: select word, align to bit 0, then extend per access width.
  always_comb begin
    rd_window = (read_address[31:4] == BASE_ADDR[31:4]);
    rd_off    = read_address[1:0];
    case (read_address[3:2])
      2'b00:   rd_word = duty;
      2'b01:   rd_word = us_cnt;
      2'b10:   rd_word = ms_cnt;
      default: rd_word = {31'h0, pwm_en};
    endcase
    rd_shift = rd_word >> {rd_off, 3'b000};
    rd_value = 32'h0;
    case (funct3)
      3'b000: rd_value = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100: rd_value = {24'h0, rd_shift[7:0]};
      3'b001: if (!rd_off[0]) rd_value = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b101: if (!rd_off[0]) rd_value = {16'h0, rd_shift[15:0]};
      3'b010: if (rd_off == 2'b00) rd_value = rd_shift;
      default: rd_value = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_hit  <= 1'b0;
      read_data <= 32'h0;
    end else begin
      read_hit  <= rd_window;
      read_data <= rd_window ? rd_value : 32'h0;
    end
  end

endmodule
